// File: rtl/adder_tree_accumulator.sv
// Frame accumulator behind the pipelined adder tree: sums 2**COUNT_LOG2 samples (or a flushed
// partial frame) and holds the total on a valid/ready port. Define ACCUM_AVERAGE_EN for rounded average output.
module adder_tree_accumulator #(
   parameter int unsigned IN_WIDTH   = 15,
   parameter int unsigned COUNT_LOG2 = 3,
   parameter int unsigned OUT_WIDTH  = IN_WIDTH + COUNT_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_sum,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_sum,
   output logic [COUNT_LOG2:0]   out_count
);

   localparam int unsigned CNT_WIDTH = COUNT_LOG2 + 1;
   localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(1) << COUNT_LOG2;

   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   state_t                state;
   logic [OUT_WIDTH-1:0]  acc;
   logic [CNT_WIDTH-1:0]  cnt;

   logic                  accept;
   logic                  transfer;
   logic                  open_frame;
   logic                  close_frame;
   logic [OUT_WIDTH-1:0]  base_acc;
   logic [CNT_WIDTH-1:0]  base_cnt;
   logic [OUT_WIDTH-1:0]  sum_next;
   logic [CNT_WIDTH-1:0]  cnt_next;
   logic [OUT_WIDTH-1:0]  result;

   // HOLD passes downstream readiness through so a frame boundary costs no bubble
   assign in_ready = (state == ST_ACCUM) || out_ready;
   assign accept   = in_valid && in_ready;
   assign transfer = out_valid && out_ready;

   // A transfer out of HOLD starts a fresh frame in the same cycle
   assign open_frame = (state == ST_ACCUM) || transfer;
   assign base_acc   = (state == ST_HOLD) ? '0 : acc;
   assign base_cnt   = (state == ST_HOLD) ? '0 : cnt;
   assign sum_next   = base_acc + (accept ? OUT_WIDTH'(in_sum) : '0);
   assign cnt_next   = base_cnt + CNT_WIDTH'(accept);

   // Flush only closes a non-empty frame
   assign close_frame = open_frame &&
                        ((accept && (cnt_next == FRAME_LEN)) || (flush && (cnt_next != '0)));

`ifdef ACCUM_AVERAGE_EN
   // Round half up; the total plus half never exceeds OUT_WIDTH
   localparam logic [OUT_WIDTH-1:0] HALF = OUT_WIDTH'(1) << (COUNT_LOG2 - 1);
   logic [OUT_WIDTH-1:0] rounded;
   assign rounded = sum_next + HALF;
   assign result  = rounded >> COUNT_LOG2;
`else
   assign result = sum_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACCUM;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         acc       <= '0;
         cnt       <= '0;
      end else if (open_frame) begin
         if (close_frame) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            out_sum   <= result;
            out_count <= cnt_next;
            acc       <= '0;
            cnt       <= '0;
         end else begin
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            acc       <= sum_next;
            cnt       <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Self-checking bench for adder_tree_accumulator: directed scenarios plus randomized traffic
// against an integer frame model. Honours ACCUM_AVERAGE_EN.
module tb_adder_tree_accumulator;

   localparam int unsigned IW = 15;
   localparam int unsigned CL = 3;
   localparam int unsigned OW = IW + CL;
   localparam int unsigned N  = 1 << CL;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [IW-1:0] in_sum;
   logic          in_ready;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_sum;
   logic [CL:0]   out_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: running frame as plain integers
   longint m_total;
   int     m_cnt;
   bit     m_hold;
   longint m_out_sum;
   int     m_out_cnt;
   bit     ready_seen;
   bit     ready_exp;

   adder_tree_accumulator #(.IN_WIDTH(IW), .COUNT_LOG2(CL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint frame_value(input longint total);
`ifdef ACCUM_AVERAGE_EN
      return (total + longint'(N / 2)) / longint'(N);
`else
      return total;
`endif
   endfunction

   task automatic model_reset();
      m_total   = 0;
      m_cnt     = 0;
      m_hold    = 1'b0;
      m_out_sum = 0;
      m_out_cnt = 0;
   endtask

   // Starts and ends at posedge+1; drives one cycle and advances the model
   task automatic step(input bit v, input logic [IW-1:0] s, input bit f, input bit ordy);
      bit acc;
      in_valid  = v;
      in_sum    = s;
      flush     = f;
      out_ready = ordy;
      #1;
      ready_seen = in_ready;
      ready_exp  = !m_hold || ordy;
      acc        = v && ready_exp;
      @(posedge clk);
      #1;
      if (!(m_hold && !ordy)) begin
         if (m_hold) begin
            m_hold  = 1'b0;
            m_total = 0;
            m_cnt   = 0;
         end
         if (acc) begin
            m_total += longint'(s);
            m_cnt++;
         end
         if (m_cnt == int'(N) || (f && m_cnt > 0)) begin
            m_hold    = 1'b1;
            m_out_sum = frame_value(m_total);
            m_out_cnt = m_cnt;
            m_total   = 0;
            m_cnt     = 0;
         end
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset: valid=%b sum=%0d count=%0d ready=%b, want 0/0/0/1",
                  out_valid, out_sum, out_count, in_ready);
      end
   endtask

   task automatic test_full_frame();
      do_reset();
      for (int i = 0; i < int'(N); i++) begin
         step(1'b1, IW'(100), 1'b0, 1'b1);
         if (i == int'(N) - 2) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
               tests_failed++;
               $display("FAIL full_frame_early: out_valid=%b want 0", out_valid);
            end
         end
      end
      tests_run++;
      if (out_valid !== 1'b1 || longint'(out_sum) != frame_value(800) || out_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL full_frame: valid=%b sum=%0d count=%0d, want 1/%0d/8",
                  out_valid, out_sum, out_count, frame_value(800));
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, IW'(i), 1'b0, 1'b1);
         tests_run++;
         if (ready_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: sample %0d in_ready=%b want 1", i, ready_seen);
         end
         if (i == 8 || i == 16) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_count !== 4'd8 ||
                longint'(out_sum) != frame_value(i == 8 ? 36 : 100)) begin
               tests_failed++;
               $display("FAIL b2b_frame: after %0d valid=%b sum=%0d count=%0d, want 1/%0d/8",
                        i, out_valid, out_sum, out_count, frame_value(i == 8 ? 36 : 100));
            end
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      step(1'b1, IW'(7), 1'b0, 1'b0);
      step(1'b1, IW'(7), 1'b0, 1'b0);
      step(1'b1, IW'(7), 1'b1, 1'b0);
      tests_run++;
      if (out_valid !== 1'b1 || longint'(out_sum) != frame_value(21) || out_count !== 4'd3) begin
         tests_failed++;
         $display("FAIL flush: valid=%b sum=%0d count=%0d, want 1/%0d/3",
                  out_valid, out_sum, out_count, frame_value(21));
      end
   endtask

   // Continues from the HOLD left by test_flush
   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, IW'(55), 1'b1, 1'b0);
         tests_run++;
         if (ready_seen !== 1'b0 || out_valid !== 1'b1 ||
             longint'(out_sum) != frame_value(21) || out_count !== 4'd3) begin
            tests_failed++;
            $display("FAIL backpressure: ready=%b valid=%b sum=%0d count=%0d, want 0/1/%0d/3",
                     ready_seen, out_valid, out_sum, out_count, frame_value(21));
         end
      end
      step(1'b1, IW'(9), 1'b0, 1'b1);
      tests_run++;
      if (ready_seen !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL release: ready=%b valid=%b, want 1/0", ready_seen, out_valid);
      end
      for (int i = 0; i < 7; i++) step(1'b1, IW'(1), 1'b0, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || longint'(out_sum) != frame_value(16) || out_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL release_frame: valid=%b sum=%0d count=%0d, want 1/%0d/8",
                  out_valid, out_sum, out_count, frame_value(16));
      end
   endtask

   task automatic test_max();
      do_reset();
      for (int i = 0; i < int'(N); i++) step(1'b1, IW'(32767), 1'b0, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || longint'(out_sum) != frame_value(262136) || out_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL max: valid=%b sum=%0d count=%0d, want 1/%0d/8",
                  out_valid, out_sum, out_count, frame_value(262136));
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, IW'(1), 1'b0, 1'b1);
      do_reset();
      tests_run++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid: valid=%b sum=%0d count=%0d, want 0/0/0",
                  out_valid, out_sum, out_count);
      end
      step(1'b0, '0, 1'b1, 1'b1);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL empty_flush: out_valid=%b want 0", out_valid);
      end
      for (int i = 0; i < int'(N); i++) step(1'b1, IW'(1), 1'b0, 1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || longint'(out_sum) != frame_value(8) || out_count !== 4'd8) begin
         tests_failed++;
         $display("FAIL post_reset_frame: valid=%b sum=%0d count=%0d, want 1/%0d/8",
                  out_valid, out_sum, out_count, frame_value(8));
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(199) == 0) begin
            do_reset();
         end else begin
            step(1'b1 && ($urandom_range(3) != 0), IW'($urandom),
                 $urandom_range(9) == 0, $urandom_range(3) != 0);
            tests_run++;
            if (ready_seen !== ready_exp) begin
               tests_failed++;
               $display("FAIL rand_ready: cycle %0d in_ready=%b want %b", c, ready_seen, ready_exp);
            end
         end
         tests_run++;
         if (out_valid !== m_hold) begin
            tests_failed++;
            $display("FAIL rand_valid: cycle %0d out_valid=%b want %b", c, out_valid, m_hold);
         end else if (m_hold && (longint'(out_sum) != m_out_sum || int'(out_count) != m_out_cnt)) begin
            tests_failed++;
            $display("FAIL rand_frame: cycle %0d sum=%0d count=%0d, want %0d/%0d",
                     c, out_sum, out_count, m_out_sum, m_out_cnt);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_full_frame();
      test_back_to_back();
      test_flush();
      test_backpressure();
      test_max();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
